ram_responder: RTL

Memory-side responder for the core's data-RAM and instruction-fetch interfaces; it sits opposite `rvcpu` and answers `RamReadEnable/RamReadAddr`, `RamWriteEnable/RamWriteAddr/RamWriteData/RamWriteMask` and `pcEnableF/pcF`. It holds one word array. Reads are combinational, matching the core's same-cycle consumption in MEM and IF. Writes are byte-masked and take effect on the clock edge. After reset a sweep FSM zero-fills the array, then a bench loader port preloads the program before the core runs; out-of-range or misaligned accesses raise a sticky error.

---
 rtl/ram_responder_if.sv | 40 ++++
 rtl/ram_responder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ram_responder_if.sv
`default_nettype none
// ============================================================================
// Module  : ram_responder_if
// Brief   : Fetch, data-RAM and loader signals between core/bench and RAM.
// Revision: 1.0
// ============================================================================
interface ram_responder_if;
  logic        pcEnableF;
  logic [63:0] pcF;
  logic [31:0] instF;
  logic        RamReadEnable;
  logic [63:0] RamReadAddr;
  logic [63:0] RamReadData;
  logic        RamWriteEnable;
  logic [63:0] RamWriteAddr;
  logic [63:0] RamWriteData;
  logic [63:0] RamWriteMask;
  logic        ld_valid;
  logic        ld_ready;
  logic [63:0] ld_addr;
  logic [63:0] ld_data;
  logic        ready;
  logic        err;
  logic [63:0] err_addr;

  modport master (
    output pcEnableF, pcF, RamReadEnable, RamReadAddr,
           RamWriteEnable, RamWriteAddr, RamWriteData, RamWriteMask,
           ld_valid, ld_addr, ld_data,
    input  instF, RamReadData, ld_ready, ready, err, err_addr
  );

  modport slave (
    input  pcEnableF, pcF, RamReadEnable, RamReadAddr,
           RamWriteEnable, RamWriteAddr, RamWriteData, RamWriteMask,
           ld_valid, ld_addr, ld_data,
    output instF, RamReadData, ld_ready, ready, err, err_addr
  );
endinterface
`default_nettype wire

// File: rtl/ram_responder.sv
`default_nettype none
// ============================================================================
// Module  : ram_responder
// Brief   : Word RAM with combinational fetch/read, masked writes, loader port.
// Revision: 1.0
// ============================================================================
module ram_responder #(
  parameter int          DEPTH = 4096,
  parameter logic [63:0] BASE  = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  ram_responder_if.slave  bus
);
  localparam int          c_AW   = $clog2(DEPTH);
  localparam logic [63:0] c_SPAN = 64'(DEPTH) << 3;
  localparam logic [31:0] c_NOP  = 32'h0000_0013;

  typedef enum logic [0:0] {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_AW-1:0] r_cnt;
  logic [c_AW-1:0] w_cnt_nxt;
  logic [63:0]     r_mem [DEPTH];
  logic            r_err;
  logic [63:0]     r_err_addr;

  logic [63:0]     w_f_off, w_r_off, w_w_off, w_l_off;
  logic            w_f_in, w_r_in, w_w_in, w_l_in;
  logic [c_AW-1:0] w_f_idx, w_r_idx, w_w_idx, w_l_idx;
  logic [63:0]     w_f_word, w_r_word;
  logic            w_unused;

  logic [31:0]     w_instF;
  logic [63:0]     w_rdata;
  logic            w_ld_ready;
  logic            w_we;
  logic [c_AW-1:0] w_widx;
  logic [63:0]     w_wdata;
  logic [63:0]     w_wmask;
  logic            w_ev;
  logic [63:0]     w_ev_addr;
  logic            w_f_bad, w_r_bad, w_w_bad, w_l_bad, w_ld_fire;

  assign w_f_off = bus.pcF          - BASE;
  assign w_r_off = bus.RamReadAddr  - BASE;
  assign w_w_off = bus.RamWriteAddr - BASE;
  assign w_l_off = bus.ld_addr      - BASE;

  assign w_f_in = (bus.pcF          >= BASE) && (w_f_off < c_SPAN);
  assign w_r_in = (bus.RamReadAddr  >= BASE) && (w_r_off < c_SPAN);
  assign w_w_in = (bus.RamWriteAddr >= BASE) && (w_w_off < c_SPAN);
  assign w_l_in = (bus.ld_addr      >= BASE) && (w_l_off < c_SPAN);

  assign w_f_idx = w_f_off[c_AW+2:3];
  assign w_r_idx = w_r_off[c_AW+2:3];
  assign w_w_idx = w_w_off[c_AW+2:3];
  assign w_l_idx = w_l_off[c_AW+2:3];

  assign w_f_word = r_mem[w_f_idx];
  assign w_r_word = r_mem[w_r_idx];

  // Byte-offset bits only matter for fetch half selection, taken from pcF.
  assign w_unused = ^{w_f_off[2:0], w_r_off[2:0], w_w_off[2:0], w_l_off[2:0]};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_instF     = 32'h0;
    w_rdata     = 64'h0;
    w_ld_ready  = 1'b0;
    w_we        = 1'b0;
    w_widx      = '0;
    w_wdata     = 64'h0;
    w_wmask     = 64'h0;
    w_f_bad     = 1'b0;
    w_r_bad     = 1'b0;
    w_w_bad     = 1'b0;
    w_l_bad     = 1'b0;
    w_ld_fire   = 1'b0;
    w_ev        = 1'b0;
    w_ev_addr   = 64'h0;

    case (r_state)
      S_INIT: begin
        w_instF   = c_NOP;
        w_we      = 1'b1;
        w_widx    = r_cnt;
        w_wmask   = '1;
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == c_AW'(DEPTH - 1)) begin
          w_state_nxt = S_READY;
        end
      end

      S_READY: begin
        w_f_bad = bus.pcEnableF && ((bus.pcF[1:0] != 2'b00) || !w_f_in);
        if (bus.pcEnableF && !w_f_bad) begin
          w_instF = bus.pcF[2] ? w_f_word[63:32] : w_f_word[31:0];
        end

        w_r_bad = bus.RamReadEnable && !w_r_in;
        if (bus.RamReadEnable && w_r_in) begin
          w_rdata = w_r_word;
        end

        w_w_bad    = bus.RamWriteEnable && !w_w_in;
        w_ld_ready = !bus.RamWriteEnable;
        w_ld_fire  = bus.ld_valid && w_ld_ready;
        w_l_bad    = w_ld_fire && !w_l_in;

        // At most one write per edge: the loader only fires with no core write.
        if (bus.RamWriteEnable && w_w_in) begin
          w_we    = 1'b1;
          w_widx  = w_w_idx;
          w_wdata = bus.RamWriteData;
          w_wmask = bus.RamWriteMask;
        end else if (w_ld_fire && w_l_in) begin
          w_we    = 1'b1;
          w_widx  = w_l_idx;
          w_wdata = bus.ld_data;
          w_wmask = '1;
        end

        w_ev = w_f_bad || w_r_bad || w_w_bad || w_l_bad;
        if (w_f_bad)      w_ev_addr = bus.pcF;
        else if (w_r_bad) w_ev_addr = bus.RamReadAddr;
        else if (w_w_bad) w_ev_addr = bus.RamWriteAddr;
        else if (w_l_bad) w_ev_addr = bus.ld_addr;
      end

      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_err      <= 1'b0;
      r_err_addr <= 64'h0;
    end else if (!r_err && w_ev) begin
      r_err      <= 1'b1;
      r_err_addr <= w_ev_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && w_we) begin
      r_mem[w_widx] <= (r_mem[w_widx] & ~w_wmask) | (w_wdata & w_wmask);
    end
  end

  assign bus.instF       = w_instF;
  assign bus.RamReadData = w_rdata;
  assign bus.ld_ready    = w_ld_ready;
  assign bus.ready       = (r_state == S_READY);
  assign bus.err         = r_err;
  assign bus.err_addr    = r_err_addr;
endmodule
`default_nettype wire
